// File: rtl/dabble_pkg.sv
// Shared constants for the double-dabble binary-to-BCD converter.
// Holds FSM states, nibble adjust constants and the seven-segment table.
package dabble_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int SEG_W      = 7;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Active-low a..g, a in bit 6; non-decimal codes blank.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

endpackage

// File: rtl/dabble_adjust_nibble.sv
// One BCD digit pre-shift correction: add 3 when the digit is 5 or more.
// The sum stays 4 bits wide; no carry leaves the nibble.
module dabble_adjust_nibble
  import dabble_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nib,
  output logic [NIBBLE_W-1:0] adj
);

  assign adj = (nib >= NIBBLE_W'(ADJ_THRESH))
             ? nib + NIBBLE_W'(ADJ_ADD)
             : nib;

endmodule

// File: rtl/bcd_dabble_converter.sv
// Serial double-dabble binary-to-BCD converter driving the upstream load line.
// Optional registered seven-segment output enabled by BCD_SEVEN_SEG_EN.
module bcd_dabble_converter
  import dabble_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  serial_in,
  output logic                  load,
  output logic                  busy,
  output logic                  done,
`ifdef BCD_SEVEN_SEG_EN
  output logic [SEG_W*DIGITS-1:0] seg_out,
`endif
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int BCD_W = NIBBLE_W * DIGITS;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_nxt;
  logic [BCD_W-1:0] bcd_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    dabble_adjust_nibble u_adj (
      .nib (bcd_q[g*NIBBLE_W +: NIBBLE_W]),
      .adj (bcd_adj[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      count <= '0;
      bcd_q <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      bcd_q <= bcd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    bcd_nxt   = bcd_q;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        busy      = 1'b1;
        bcd_nxt   = '0;
        count_nxt = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        bcd_nxt   = (bcd_adj << 1) | BCD_W'(serial_in);
        count_nxt = count + 1'b1;
        if (count == CNT_W'(WIDTH - 1))
          state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // Held start chains straight into the next load.
        state_nxt = start ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bcd_out = bcd_q;

`ifdef BCD_SEVEN_SEG_EN
  logic [SEG_W*DIGITS-1:0] seg_q;
  logic [SEG_W*DIGITS-1:0] seg_nxt;

  always_comb begin
    seg_nxt = '1;
    for (int i = 0; i < DIGITS; i++)
      seg_nxt[i*SEG_W +: SEG_W] =
        SEG_TABLE[bcd_nxt[i*NIBBLE_W +: NIBBLE_W]];
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear)     seg_q <= '1;
    else if (busy) seg_q <= seg_nxt;
  end

  assign seg_out = seg_q;
`endif

endmodule
